// File: rtl/int_divide_pipe_pkg.sv
// Shared types and constants for the pipe-2 integer divide unit.
`timescale 1ns/1ps
package int_divide_pipe_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned CNT_W        = $clog2(XLEN);
  localparam int unsigned IDIV_LATENCY = 33;

  typedef enum logic [1:0] {
    IDIV_DIV  = 2'd0,
    IDIV_DIVU = 2'd1,
    IDIV_REM  = 2'd2,
    IDIV_REMU = 2'd3
  } idiv_op_t;

  typedef struct packed {
    logic        valid;
    logic [5:0]  rob_idx;
    logic [6:0]  pdst;
    logic [31:0] pc;
  } micro_op_t;

  function automatic logic op_is_signed(idiv_op_t op);
    return (op == IDIV_DIV) || (op == IDIV_REM);
  endfunction

  function automatic logic op_is_rem(idiv_op_t op);
    return (op == IDIV_REM) || (op == IDIV_REMU);
  endfunction

endpackage

// File: rtl/int_divide_pipe_if.sv
// Issue-side request and writeback-side result bundle for the divide unit.
`timescale 1ns/1ps
interface int_divide_pipe_if;
  import int_divide_pipe_pkg::*;

  logic            in_valid;
  idiv_op_t        in_op;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  micro_op_t       in_uop;
  logic            busy;
  logic            out_valid;
  logic [XLEN-1:0] out_data;
  micro_op_t       out_uop;

  modport master (
    output in_valid, in_op, in_rs1, in_rs2, in_uop,
    input  busy, out_valid, out_data, out_uop
  );

  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2, in_uop,
    output busy, out_valid, out_data, out_uop
  );

endinterface

// File: rtl/int_divide_step.sv
// One radix-2 restoring iteration on magnitudes: shift {rem, quo} left, subtract if it fits.
`timescale 1ns/1ps
module int_divide_step
  import int_divide_pipe_pkg::*;
(
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] rem_sh;
  logic [XLEN:0] trial;

  assign rem_sh = {rem, quo[XLEN-1]};
  assign trial  = rem_sh - {1'b0, divisor};

  // rem_sh < 2*divisor always holds, so the top bit of trial is its sign
  always_comb begin
    rem_next = rem_sh[XLEN-1:0];
    quo_next = {quo[XLEN-2:0], 1'b0};
    if (!trial[XLEN]) begin
      rem_next = trial[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/int_divide_pipe.sv
// Multi-cycle DIV/DIVU/REM/REMU unit for pipe 2; holds busy while an op is in flight.
`timescale 1ns/1ps
module int_divide_pipe
  import int_divide_pipe_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  int_divide_pipe_if.slave  io
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state;
  idiv_op_t         op_q;
  logic             q_neg;
  logic             r_neg;
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  div_q;
  logic [CNT_W-1:0] cnt_q;

  logic             in_signed;
  logic             rs1_neg;
  logic             rs2_neg;
  logic [XLEN-1:0]  abs_rs1;
  logic [XLEN-1:0]  abs_rs2;
  logic             div_zero;
  logic             overflow;
  logic             accept;
  logic [XLEN-1:0]  special_data;
  logic [XLEN-1:0]  step_rem;
  logic [XLEN-1:0]  step_quo;
  logic [XLEN-1:0]  final_data;

  // Operand decode at accept: magnitudes, signs and the two no-iteration cases
  always_comb begin
    in_signed = op_is_signed(io.in_op);
    rs1_neg   = in_signed & io.in_rs1[XLEN-1];
    rs2_neg   = in_signed & io.in_rs2[XLEN-1];
    abs_rs1   = rs1_neg ? (~io.in_rs1 + XLEN'(1)) : io.in_rs1;
    abs_rs2   = rs2_neg ? (~io.in_rs2 + XLEN'(1)) : io.in_rs2;
    div_zero  = (io.in_rs2 == '0);
    overflow  = in_signed && (io.in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (io.in_rs2 == '1);
    accept    = (state == IDLE) && io.in_valid && io.in_uop.valid;
    // Overflow quotient equals rs1 itself; divide-by-zero remainder is rs1 too
    if (op_is_rem(io.in_op)) special_data = div_zero ? io.in_rs1 : '0;
    else                     special_data = div_zero ? '1 : io.in_rs1;
  end

  int_divide_step u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (div_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  // Sign fixup applied on the last iteration's outputs
  always_comb begin
    if (op_is_rem(op_q)) final_data = r_neg ? (~step_rem + XLEN'(1)) : step_rem;
    else                 final_data = q_neg ? (~step_quo + XLEN'(1)) : step_quo;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      op_q         <= IDIV_DIV;
      q_neg        <= 1'b0;
      r_neg        <= 1'b0;
      rem_q        <= '0;
      quo_q        <= '0;
      div_q        <= '0;
      cnt_q        <= '0;
      io.busy      <= 1'b0;
      io.out_valid <= 1'b0;
      io.out_data  <= '0;
      io.out_uop   <= '0;
    end else begin
      io.out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q       <= io.in_op;
            io.out_uop <= io.in_uop;
            io.busy    <= 1'b1;
            if (div_zero || overflow) begin
              state        <= DONE;
              io.out_valid <= 1'b1;
              io.out_data  <= special_data;
            end else begin
              state <= DIVIDE;
              cnt_q <= '0;
              rem_q <= '0;
              quo_q <= abs_rs1;
              div_q <= abs_rs2;
              q_neg <= rs1_neg ^ rs2_neg;
              r_neg <= rs1_neg;
            end
          end
        end
        DIVIDE: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN-1)) begin
            state        <= DONE;
            io.out_valid <= 1'b1;
            io.out_data  <= final_data;
          end
        end
        DONE: begin
          state   <= IDLE;
          io.busy <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          io.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_divide_pipe.sv
// Randomised scoreboard bench for int_divide_pipe against an arithmetic RISC-V M model.
`timescale 1ns/1ps
module tb_int_divide_pipe;
  import int_divide_pipe_pkg::*;

  localparam time PERIOD = 10;

  typedef struct {
    logic [31:0] data;
    micro_op_t   uop;
    time         due;
  } exp_t;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb[$];

  int_divide_pipe_if dif();

  int_divide_pipe dut (
    .clock (clock),
    .reset (reset),
    .io    (dif.slave)
  );

  initial begin
    clock = 1'b0;
    forever #(PERIOD/2) clock = ~clock;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // RISC-V M semantics from plain integer arithmetic
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int  sa;
    int  sbv;
    logic ovf;
    sa  = a;
    sbv = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'd0:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sbv);
      2'd1:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'd2:    return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sbv);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    logic sgn;
    sgn = (op == 2'd0) || (op == 2'd2);
    if (b == 0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return 33;
  endfunction

  function automatic micro_op_t mk_uop();
    micro_op_t u;
    u.valid   = 1'b1;
    u.rob_idx = 6'($urandom);
    u.pdst    = 7'($urandom);
    u.pc      = $urandom;
    return u;
  endfunction

  // Starts at any point, returns at the negedge after the accept edge
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output time t_acc);
    exp_t e;
    int   n;
    micro_op_t u;
    u = mk_uop();
    n = 0;
    @(negedge clock);
    while (dif.busy && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) check("idle_wait_timeout", 64'(n), 64'(0));
    dif.in_valid = 1'b1;
    dif.in_op    = idiv_op_t'(op);
    dif.in_rs1   = a;
    dif.in_rs2   = b;
    dif.in_uop   = u;
    @(posedge clock);
    t_acc = $time;
    e.data = ref_result(op, a, b);
    e.uop  = u;
    e.due  = t_acc + time'(ref_latency(op, a, b) - 1) * PERIOD + PERIOD/2;
    sb.push_back(e);
    @(negedge clock);
    dif.in_valid = 1'b0;
  endtask

  // Monitor: every result strobe must match the oldest outstanding expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && dif.out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 64'(dif.out_data), 64'(0));
        end else begin
          e = sb.pop_front();
          check("out_data", 64'(dif.out_data), 64'(e.data));
          check("out_uop", 64'(dif.out_uop), 64'(e.uop));
          check("out_time", 64'($time), 64'(e.due));
        end
      end
    end
  end

  function automatic logic [31:0] pick_operand();
    logic [31:0] corners [6];
    corners[0] = 32'h0;
    corners[1] = 32'h1;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'h7FFF_FFFF;
    corners[5] = 32'($urandom_range(0, 20));
    if ($urandom_range(0, 9) < 4) return corners[$urandom_range(0, 5)];
    if ($urandom_range(0, 1) == 1) return $urandom >> $urandom_range(0, 31);
    return $urandom;
  endfunction

  initial begin
    time t;
    int  n;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    dif.in_valid = 1'b0;
    dif.in_op    = IDIV_DIV;
    dif.in_rs1   = '0;
    dif.in_rs2   = '0;
    dif.in_uop   = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_busy", 64'(dif.busy), 64'(0));
    check("reset_out_valid", 64'(dif.out_valid), 64'(0));
    check("reset_out_data", 64'(dif.out_data), 64'(0));
    check("reset_out_uop", 64'(dif.out_uop), 64'(0));
    reset = 1'b0;

    // Normal latency and busy window
    issue(2'd0, 32'd100, 32'd7, t);
    check("busy_t+1", 64'(dif.busy), 64'(1));
    repeat (32) @(negedge clock);
    check("busy_t+33", 64'(dif.busy), 64'(1));
    @(negedge clock);
    check("busy_t+34", 64'(dif.busy), 64'(0));
    issue(2'd2, 32'd100, 32'd7, t);
    issue(2'd0, 32'hFFFF_FFF9, 32'd2, t);
    issue(2'd2, 32'hFFFF_FFF9, 32'd2, t);
    issue(2'd1, 32'hFFFF_FFF9, 32'd2, t);

    // Special cases, one-cycle latency
    issue(2'd1, 32'd5, 32'd0, t);
    issue(2'd2, 32'd5, 32'd0, t);
    issue(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, t);
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, t);
    issue(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, t);

    // Request presented while busy is dropped
    issue(2'd0, 32'd1234, 32'd11, t);
    repeat (3) @(negedge clock);
    dif.in_valid = 1'b1;
    dif.in_op    = IDIV_DIVU;
    dif.in_rs1   = 32'd77;
    dif.in_rs2   = 32'd0;
    dif.in_uop   = mk_uop();
    @(negedge clock);
    dif.in_valid = 1'b0;
    repeat (35) @(negedge clock);
    check("pending_after_drop", 64'(sb.size()), 64'(0));

    // A uop with valid=0 is never accepted
    dif.in_valid = 1'b1;
    dif.in_rs2   = 32'd0;
    dif.in_uop   = '0;
    repeat (3) @(negedge clock);
    dif.in_valid = 1'b0;
    check("invalid_uop_busy", 64'(dif.busy), 64'(0));

    // Reset mid-division discards the op
    issue(2'd0, 32'd1000, 32'd3, t);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    sb.delete();
    @(negedge clock);
    check("busy_after_reset", 64'(dif.busy), 64'(0));
    reset = 1'b0;
    repeat (31) @(negedge clock);
    issue(2'd1, 32'd9, 32'd3, t);

    // Randomised operands and ops
    for (int i = 0; i < 80; i++)
      issue(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), t);

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("drain", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/int_divide_pipe.md
# int_divide_pipe

Multi-cycle integer divide unit for execution pipe 2 (ALU+IntDiv), directly downstream of the integer issue queue and register read. It accepts one DIV/DIVU/REM/REMU uop at a time. It computes the result with a radix-2 restoring algorithm and holds the pipe's `ex_busy` high while occupied, so the issue queue stops selecting this pipe. It returns the result with the original uop to writeback.

## Interface
- `XLEN`, 32: operand/result width.
- `clock` input 1: clock.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: uop presented this cycle; ignored while `busy`.
- `in_op` input 2: 0=DIV, 1=DIVU, 2=REM, 3=REMU.
- `in_rs1` input XLEN: dividend.
- `in_rs2` input XLEN: divisor.
- `in_uop` input micro_op_t: carried unchanged to `out_uop`.
- `busy` output 1: unit occupied; drives `ex_busy[2]`.
- `out_valid` output 1: one-cycle result strobe.
- `out_data` output XLEN: quotient or remainder.
- `out_uop` output micro_op_t: uop captured at accept.

## Operation
- FSM states IDLE, DIVIDE, DONE. `busy = (state != IDLE)`.
- Accept: in IDLE with `in_valid & in_uop.valid`. Latch op, uop and operands.
  - Signed ops: latch absolute values plus `q_neg = rs1[XLEN-1]^rs2[XLEN-1]` and `r_neg = rs1[XLEN-1]`.
  - Unsigned ops: `q_neg = r_neg = 0`.
- Special cases decided at accept. Go IDLE→DONE directly, no iteration:
  - divisor 0: quotient = all ones, remainder = rs1.
  - signed, rs1 = 0x80000000, rs2 = 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- Normal path, IDLE→DIVIDE with 5-bit counter = 0. Each DIVIDE cycle:
  - Shift {rem, quo} left 1. Trial = rem_shifted − divisor, computed XLEN+1 wide.
  - If trial ≥ 0: rem = trial, quo[0] = 1.
  - Counter increments; at counter = XLEN−1, go to DONE.
- DONE: `out_valid = 1`.
  - `out_data` = quotient (negated if `q_neg`) for DIV/DIVU, or remainder (negated if `r_neg`) for REM/REMU.
  - Special-case results bypass sign fixup.
  - DONE→IDLE unconditionally.
- No backpressure from writeback; the result is presented exactly once.
- An uop with `valid=0` is never accepted, even when `in_valid=1`.

## Timing
- Reset values: state IDLE, `busy`=0, `out_valid`=0, `out_data`=0, `out_uop`=0, counter 0.
- Accept sampled at rising edge t.
  - `busy` is high from cycle t+1.
  - Normal op: DIVIDE in cycles t+1..t+32, DONE and `out_valid` in cycle t+33. Latency 33 cycles.
  - Special case: DONE and `out_valid` in cycle t+1. Latency 1 cycle.
- `busy` falls the cycle after DONE. The next accept is earliest at the edge ending that IDLE cycle.
  - Normal-op throughput: 1 op per 34 cycles.
- `out_data` and `out_uop` are valid only while `out_valid` is high. They are registered, with no combinational path from inputs.
- Reset mid-operation (any state): returns to IDLE next cycle. The in-flight op is discarded and no `out_valid` is produced.
- Inputs arriving while `busy` are dropped. Upstream must not present them because the issue queue gates this pipe on `ex_busy`.

## Structure
- Add the `idiv_op_t` enum (DIV, DIVU, REM, REMU) and `IDIV_LATENCY = 33` to `micro_op.svh`.
- Reuse `micro_op_t` unchanged.
- One natural sub-module: `int_divide_step`, a combinational single restoring iteration (rem, quo, divisor → rem', quo'). Instantiated once.
- FSM, sign handling and special cases stay in the top module.

## Test plan
- DIV 100 / 7 accepted at t → `out_valid` only at t+33, `out_data` = 14; REM 100 % 7 → 2; `busy` high over t+1..t+33.
- DIV −7 / 2 → 0xFFFFFFFD (−3); REM −7 % 2 → 0xFFFFFFFF (−1); DIVU 0xFFFFFFF9 / 2 → 0x7FFFFFFC.
- DIVU 5 / 0 → 0xFFFFFFFF at t+1; REM 5 % 0 → 5 at t+1; DIV 0x80000000 / −1 → 0x80000000 at t+1, REM → 0.
- Second `in_valid` asserted at t+5 while busy → ignored. Exactly one `out_valid` at t+33, and `out_uop` equals the first uop.
- Reset asserted at t+10 of a DIV → `busy`=0 at t+11, no `out_valid` through t+40. A new DIVU 9/3 accepted afterwards → 3 after 33 cycles.
- Randomized signed/unsigned operands against a reference model, including 0, 1, −1, 0x80000000, 0x7FFFFFFF as dividend/divisor → all results match RISC-V M semantics.
